glitch_sequencer: RTL and testbench
===================================

GLITCH_SEQUENCER -- requirements
Module: glitch_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; rst  in  1  synchronous, active-high reset; clock clk.
REQ-002 SHALL have ports: glitch_en  in  1  arm enable (config register); glitch_pos  in  16  coarse delay, trigger to first glitch, in clk cycles; glitch_width  in  16  glitch_sel high time per burst, in cycles; glitch_period  in  16  burst start-to-start spacing, in cycles (0 = single burst).
REQ-003 SHALL have ports: glitch_pos_fine  in  16  phase-shifter setting; fine_ready  in  1  phase shifter settled; trigger  in  1  target trigger, synchronous to clk.
REQ-004 SHALL have ports: glitch_sel  out  1  selects glitchy clock; fine_delay  out  16  value for phase shifter; fine_load  out  1  one-cycle load strobe; busy  out  1  sequence in progress; done  out  1  one-cycle completion pulse; burst_cnt  out  16  bursts issued in current sequence.

Function
REQ-010 SHALL implement states IDLE, LOAD, WAIT_FINE, ARM, DELAY, GLITCH, GAP, DONE; all outputs registered.
REQ-011 IDLE->LOAD when glitch_en=1; LOAD SHALL assert fine_load for exactly one cycle, drive fine_delay=glitch_pos_fine, then go to WAIT_FINE.
REQ-012 WAIT_FINE->ARM on the first cycle fine_ready=1; there is no timeout.
REQ-013 ARM SHALL detect a trigger rising edge (trigger=1, previous sample 0); a trigger already high on entry to ARM SHALL NOT count as an edge.
REQ-014 On the edge (cycle E0), the block SHALL latch pos, width and period into internal registers, clear burst_cnt and enter DELAY; later config changes SHALL NOT affect the running sequence.
REQ-015 glitch_sel SHALL first be high exactly pos+1 cycles after E0 and SHALL remain high for exactly width cycles.
REQ-016 width=0: GLITCH SHALL be skipped, glitch_sel SHALL stay 0, burst_cnt SHALL still increment, and the sequence SHALL proceed as if the burst had completed.
REQ-017 At the end of each burst, burst_cnt SHALL increment, saturating at 16'hFFFF.
REQ-018 After a burst: if period=0 or trigger=0, go to DONE; otherwise, if period>width, GAP for period-width cycles, then GLITCH; if period<=width, re-enter GLITCH immediately, so glitch_sel stays high.
REQ-019 DONE SHALL pulse done for one cycle, then go to ARM if glitch_en=1, else IDLE; burst_cnt SHALL hold until the next E0.
REQ-020 busy SHALL be 1 in DELAY, GLITCH and GAP, and 0 otherwise.
REQ-021 glitch_en=0 in any state other than IDLE SHALL force IDLE next cycle, with glitch_sel=0 and no done pulse.
REQ-022 Counters SHALL be 16-bit down-counters with no wrap; a load value of 0 SHALL mean one cycle in DELAY.

Reset
REQ-030 On rst: state=IDLE, glitch_sel=0, fine_load=0, fine_delay=0, busy=0, done=0, burst_cnt=0, trigger history=0, latched params=0.
REQ-031 rst SHALL take priority over all other inputs, including mid-burst, and glitch_sel SHALL be 0 in the cycle after rst is sampled.

Configuration
REQ-040 Macro GLITCH_SEQ_FINE_DELAY_EN: when defined, LOAD and WAIT_FINE SHALL behave as in REQ-011 and REQ-012.
REQ-041 Without GLITCH_SEQ_FINE_DELAY_EN: IDLE->ARM directly, fine_load=0, fine_delay=0, and fine_ready and glitch_pos_fine SHALL be ignored.

Verification
REQ-050 en=1, fine_ready high 3 cycles after fine_load, pos=14, width=3, period=0, trigger pulse -> one fine_load with fine_delay=280 (pos_fine=280), glitch_sel high cycles E0+15..E0+17, done at E0+18, burst_cnt=1.
REQ-051 pos=2, width=2, period=5, trigger held high for 3 bursts then low -> glitch_sel pattern 11000 repeating, burst_cnt=3, one done pulse.
REQ-052 width=4, period=3, trigger high 2 bursts -> glitch_sel continuously high for 8 cycles.
REQ-053 glitch_en dropped at cycle 2 of GLITCH -> glitch_sel=0 next cycle, state IDLE, no done pulse.
REQ-054 trigger already high on entry to ARM -> no sequence starts until trigger falls and rises again; a glitch_pos write during DELAY leaves the timing unchanged.
REQ-055 rst asserted mid-GAP -> all outputs at reset values next cycle; build without the macro gives fine_load always 0.

Source files
------------

// File: rtl/glitch_sequencer_if.sv
// Configuration, trigger and glitch-control signals shared by glitch_sequencer and its driver.
interface glitch_sequencer_if;
  logic        glitch_en;
  logic [15:0] glitch_pos;
  logic [15:0] glitch_width;
  logic [15:0] glitch_period;
  logic [15:0] glitch_pos_fine;
  logic        fine_ready;
  logic        trigger;
  logic        glitch_sel;
  logic [15:0] fine_delay;
  logic        fine_load;
  logic        busy;
  logic        done;
  logic [15:0] burst_cnt;

  modport master (
    output glitch_en, glitch_pos, glitch_width, glitch_period, glitch_pos_fine,
           fine_ready, trigger,
    input  glitch_sel, fine_delay, fine_load, busy, done, burst_cnt
  );

  modport slave (
    input  glitch_en, glitch_pos, glitch_width, glitch_period, glitch_pos_fine,
           fine_ready, trigger,
    output glitch_sel, fine_delay, fine_load, busy, done, burst_cnt
  );
endinterface

// File: rtl/glitch_sequencer.sv
// Clock-glitch sequencer: arms on a trigger rising edge, waits a coarse delay, then issues glitch_sel bursts.
// Define GLITCH_SEQ_FINE_DELAY_EN to add the phase-shifter load / settle handshake before arming.
module glitch_sequencer (
  input  logic              clk,
  input  logic              rst,
  glitch_sequencer_if.slave bus
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ARM       = 3'd3;
  localparam logic [2:0] DELAY     = 3'd4;
  localparam logic [2:0] GLITCH    = 3'd5;
  localparam logic [2:0] GAP       = 3'd6;
  localparam logic [2:0] DONE      = 3'd7;
`ifdef GLITCH_SEQ_FINE_DELAY_EN
  localparam logic [2:0] LOAD      = 3'd1;
  localparam logic [2:0] WAIT_FINE = 3'd2;
  localparam logic [2:0] ENTRY     = LOAD;
`else
  localparam logic [2:0] ENTRY     = ARM;
`endif

  logic [2:0]  state_r;
  logic [2:0]  state_nx_s;
  logic [15:0] cnt_r;
  logic [15:0] cnt_nx_s;
  logic [15:0] width_r;
  logic [15:0] period_r;
  logic [15:0] burst_cnt_r;
  logic        trig_prev_r;
  logic        glitch_sel_r;
  logic        busy_r;
  logic        done_r;
  logic        start_s;
  logic        burst_end_s;
  logic [2:0]  after_state_s;
  logic [15:0] after_cnt_s;

  // Successor of a completed burst (real or zero-width).
  always_comb begin
    after_state_s = DONE;
    after_cnt_s   = 16'd0;
    if (period_r == 16'd0 || !bus.trigger) begin
      after_state_s = DONE;
      after_cnt_s   = 16'd0;
    end else if (period_r > width_r) begin
      after_state_s = GAP;
      after_cnt_s   = period_r - width_r;
    end else begin
      after_state_s = GLITCH;
      after_cnt_s   = width_r;
    end
  end

  // Next-state logic; the counter holds the remaining cycles of DELAY, GLITCH or GAP.
  always_comb begin
    state_nx_s  = state_r;
    cnt_nx_s    = cnt_r;
    start_s     = 1'b0;
    burst_end_s = 1'b0;
    if (state_r != IDLE && !bus.glitch_en) begin
      state_nx_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.glitch_en) state_nx_s = ENTRY;
          else               state_nx_s = IDLE;
        end
`ifdef GLITCH_SEQ_FINE_DELAY_EN
        LOAD: state_nx_s = WAIT_FINE;
        WAIT_FINE: begin
          if (bus.fine_ready) state_nx_s = ARM;
          else                state_nx_s = WAIT_FINE;
        end
`endif
        ARM: begin
          if (bus.trigger && !trig_prev_r) begin
            start_s    = 1'b1;
            state_nx_s = DELAY;
            cnt_nx_s   = bus.glitch_pos;
          end else begin
            state_nx_s = ARM;
          end
        end
        // A count of 0 or 1 both mean this is the last cycle here.
        DELAY, GAP: begin
          if (cnt_r > 16'd1) begin
            cnt_nx_s = cnt_r - 16'd1;
          end else if (width_r == 16'd0) begin
            burst_end_s = 1'b1;
            state_nx_s  = after_state_s;
            cnt_nx_s    = after_cnt_s;
          end else begin
            state_nx_s = GLITCH;
            cnt_nx_s   = width_r;
          end
        end
        GLITCH: begin
          if (cnt_r > 16'd1) begin
            cnt_nx_s = cnt_r - 16'd1;
          end else begin
            burst_end_s = 1'b1;
            state_nx_s  = after_state_s;
            cnt_nx_s    = after_cnt_s;
          end
        end
        DONE:    state_nx_s = ARM;
        default: state_nx_s = IDLE;
      endcase
    end
  end

  // State, latched parameters, burst counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= 16'd0;
      width_r      <= 16'd0;
      period_r     <= 16'd0;
      burst_cnt_r  <= 16'd0;
      trig_prev_r  <= 1'b0;
      glitch_sel_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      cnt_r       <= cnt_nx_s;
      trig_prev_r <= bus.trigger;
      if (start_s) begin
        width_r     <= bus.glitch_width;
        period_r    <= bus.glitch_period;
        burst_cnt_r <= 16'd0;
      end else if (burst_end_s && burst_cnt_r != 16'hFFFF) begin
        burst_cnt_r <= burst_cnt_r + 16'd1;
      end
      glitch_sel_r <= (state_nx_s == GLITCH);
      busy_r       <= (state_nx_s == DELAY) || (state_nx_s == GLITCH) || (state_nx_s == GAP);
      done_r       <= (state_nx_s == DONE);
    end
  end

`ifdef GLITCH_SEQ_FINE_DELAY_EN
  logic        fine_load_r;
  logic [15:0] fine_delay_r;

  // Phase-shifter strobe and value, captured as LOAD is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      fine_load_r  <= 1'b0;
      fine_delay_r <= 16'd0;
    end else begin
      fine_load_r <= (state_nx_s == LOAD);
      if (state_nx_s == LOAD) fine_delay_r <= bus.glitch_pos_fine;
    end
  end

  assign bus.fine_load  = fine_load_r;
  assign bus.fine_delay = fine_delay_r;
`else
  logic unused_fine_s;
  assign unused_fine_s  = bus.fine_ready ^ (^bus.glitch_pos_fine);
  assign bus.fine_load  = 1'b0;
  assign bus.fine_delay = 16'd0;
`endif

  assign bus.glitch_sel = glitch_sel_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.burst_cnt  = burst_cnt_r;
endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed bench for glitch_sequencer: vector table of single sequences plus hand-written corner cases.
module tb_glitch_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   fine_load_cnt = 0;

  glitch_sequencer_if bus();
  glitch_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.fine_load === 1'b1) fine_load_cnt++;

  typedef struct {
    int pos; int width; int period; int trig_len;
    int first_hi; int last_hi; int hi_cnt; int done_at; int bursts;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " glitch_sel"}, int'(bus.glitch_sel), 0);
    check({tag, " busy"}, int'(bus.busy), 0);
    check({tag, " done"}, int'(bus.done), 0);
    check({tag, " burst_cnt"}, int'(bus.burst_cnt), 0);
    check({tag, " fine_load"}, int'(bus.fine_load), 0);
    check({tag, " fine_delay"}, int'(bus.fine_delay), 0);
  endtask

  task automatic start_armed(input int pos, input int width, input int period);
    bus.trigger = 1'b0;
    bus.glitch_en = 1'b0;
    bus.fine_ready = 1'b1;
    bus.glitch_pos_fine = 16'd280;
    bus.glitch_pos = 16'(pos);
    bus.glitch_width = 16'(width);
    bus.glitch_period = 16'(period);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.glitch_en = 1'b1;
    repeat (4) tick();
  endtask

  // Cycle k=0 is the trigger edge cycle E0; each iteration samples cycle k then advances.
  task automatic observe(input int trig_len, input int chg_at, input int drop_at,
                         output int first_hi, output int last_hi, output int hi_cnt,
                         output int done_at, output int done_cnt, output int busy1,
                         output int bcnt, output int busy_end);
    first_hi = -1; last_hi = -1; hi_cnt = 0; done_at = -1; done_cnt = 0; busy1 = 0;
    for (int k = 0; k < 40; k++) begin
      bus.trigger = (k < trig_len);
      if (k == chg_at) begin
        bus.glitch_pos = 16'd20;
        bus.glitch_width = 16'd9;
      end
      if (k == drop_at) bus.glitch_en = 1'b0;
      if (bus.glitch_sel === 1'b1) begin
        if (first_hi < 0) first_hi = k;
        last_hi = k;
        hi_cnt++;
      end
      if (bus.done === 1'b1) begin
        if (done_at < 0) done_at = k;
        done_cnt++;
      end
      if (k == 1) busy1 = int'(bus.busy);
      tick();
    end
    bcnt = int'(bus.burst_cnt);
    busy_end = int'(bus.busy);
  endtask

  initial begin
    vec_t vecs[8];
    int fh, lh, hc, da, dc, b1, bc, be, cnt, base;

    vecs[0] = '{14, 3, 0, 1,   15, 17, 3, 18, 1};
    vecs[1] = '{2, 2, 5, 11,   3, 14, 6, 15, 3};
    vecs[2] = '{1, 4, 3, 7,    2, 9, 8, 10, 2};
    vecs[3] = '{3, 0, 0, 1,    -1, -1, 0, 4, 1};
    vecs[4] = '{3, 0, 2, 5,    -1, -1, 0, 6, 2};
    vecs[5] = '{1, 2, 2, 4,    2, 5, 4, 6, 2};
    vecs[6] = '{1, 1, 0, 1,    2, 2, 1, 3, 1};
    vecs[7] = '{2, 3, 10, 2,   3, 5, 3, 6, 1};

    rst = 1'b1;
    bus.glitch_en = 1'b0; bus.trigger = 1'b0; bus.fine_ready = 1'b0;
    bus.glitch_pos = 16'd0; bus.glitch_width = 16'd0; bus.glitch_period = 16'd0;
    bus.glitch_pos_fine = 16'd0;
    tick();
    tick();
    check_reset_outputs("reset");

    for (int i = 0; i < 8; i++) begin
      start_armed(vecs[i].pos, vecs[i].width, vecs[i].period);
      observe(vecs[i].trig_len, -1, -1, fh, lh, hc, da, dc, b1, bc, be);
      check($sformatf("vec%0d first_hi", i), fh, vecs[i].first_hi);
      check($sformatf("vec%0d last_hi", i), lh, vecs[i].last_hi);
      check($sformatf("vec%0d hi_cnt", i), hc, vecs[i].hi_cnt);
      check($sformatf("vec%0d done_at", i), da, vecs[i].done_at);
      check($sformatf("vec%0d done_cnt", i), dc, 1);
      check($sformatf("vec%0d burst_cnt", i), bc, vecs[i].bursts);
      check($sformatf("vec%0d busy_delay", i), b1, 1);
      check($sformatf("vec%0d busy_end", i), be, 0);
    end

    // Enable dropped on the second GLITCH cycle (GLITCH spans k=3..7).
    start_armed(2, 5, 0);
    observe(40, -1, 4, fh, lh, hc, da, dc, b1, bc, be);
    check("en_drop first_hi", fh, 3);
    check("en_drop last_hi", lh, 4);
    check("en_drop hi_cnt", hc, 2);
    check("en_drop done_cnt", dc, 0);
    check("en_drop burst_cnt", bc, 0);
    check("en_drop busy_end", be, 0);

    // Trigger already high when ARM is entered must not start a sequence.
    bus.glitch_pos = 16'd4; bus.glitch_width = 16'd2; bus.glitch_period = 16'd0;
    bus.glitch_en = 1'b0; bus.fine_ready = 1'b1; bus.trigger = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.glitch_en = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.busy === 1'b1 || bus.glitch_sel === 1'b1) cnt++;
      tick();
    end
    check("trig_high_entry active_cycles", cnt, 0);
    bus.trigger = 1'b0;
    tick();
    observe(40, 2, -1, fh, lh, hc, da, dc, b1, bc, be);
    check("pos_write_in_delay first_hi", fh, 5);
    check("pos_write_in_delay hi_cnt", hc, 2);
    check("pos_write_in_delay done_at", da, 7);
    check("pos_write_in_delay burst_cnt", bc, 1);
    bus.trigger = 1'b0;
    tick();
    observe(1, -1, -1, fh, lh, hc, da, dc, b1, bc, be);
    check("rearm first_hi", fh, 21);
    check("rearm last_hi", lh, 29);
    check("rearm done_at", da, 30);
    check("rearm burst_cnt", bc, 1);

    // Reset in the middle of GAP (GLITCH k=2..3, GAP k=4..11).
    start_armed(1, 2, 10);
    bus.trigger = 1'b1;
    repeat (6) tick();
    check("mid_gap busy", int'(bus.busy), 1);
    check("mid_gap burst_cnt", int'(bus.burst_cnt), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("rst_mid_gap");

    // Reset in the middle of GLITCH (GLITCH k=2..6).
    start_armed(1, 5, 0);
    bus.trigger = 1'b1;
    repeat (3) tick();
    check("mid_glitch glitch_sel", int'(bus.glitch_sel), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_glitch glitch_sel", int'(bus.glitch_sel), 0);
    check("rst_mid_glitch busy", int'(bus.busy), 0);

`ifdef GLITCH_SEQ_FINE_DELAY_EN
    bus.glitch_en = 1'b0; bus.trigger = 1'b0; bus.fine_ready = 1'b0;
    bus.glitch_pos_fine = 16'd280;
    bus.glitch_pos = 16'd14; bus.glitch_width = 16'd3; bus.glitch_period = 16'd0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    base = fine_load_cnt;
    bus.glitch_en = 1'b1;
    tick();
    check("fine load strobe", int'(bus.fine_load), 1);
    check("fine delay value", int'(bus.fine_delay), 280);
    tick();
    check("fine load one_cycle", int'(bus.fine_load), 0);
    tick();
    tick();
    bus.fine_ready = 1'b1;
    check("fine wait busy", int'(bus.busy), 0);
    tick();
    observe(1, -1, -1, fh, lh, hc, da, dc, b1, bc, be);
    check("fine seq first_hi", fh, 15);
    check("fine seq last_hi", lh, 17);
    check("fine seq done_at", da, 18);
    check("fine seq burst_cnt", bc, 1);
    check("fine load pulses", fine_load_cnt - base, 1);
`else
    base = 0;
    check("no_fine fine_load pulses", fine_load_cnt - base, 0);
    check("no_fine fine_delay", int'(bus.fine_delay), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
